sync_pfifo: RTL
===============

Name: sync_pfifo

Overview:
Single-clock packet FIFO, the synchronous successor of the edge-triggered packet FIFO. The writer streams words speculatively, then commits or drops the open packet. The reader sees only committed words and gets an end-of-packet marker on the last word. Adds synchronous reset, level/free counters, an almost-full threshold and defined same-cycle event priorities. Sits between a packet producer (e.g. a frame receiver) and a consumer on one clock domain.

Parameters:
W, 8, data word width
ORDER, 4, log2 of buffer depth; DEPTH = 2**ORDER words
COUNT_ORDER, 2, log2 of committed-packet capacity; PKTS = 2**COUNT_ORDER
AF, 2, almost-full threshold; afull asserts when free slots < AF (1 ≤ AF ≤ DEPTH)

Ports:
clock  in  1  sole clock; all state updates on rising edge
reset  in  1  synchronous, active-high
in  in  W  write data
put  in  1  write strobe, one word per cycle when accepted
commit  in  1  close open packet and make it visible to the reader
drop  in  1  discard open (uncommitted) packet
full  out  1  put will not be accepted this cycle
afull  out  1  free < AF
free  out  ORDER+1  DEPTH minus all stored words (committed + open)
out  out  W  read data, registered
last  out  1  qualifies out: word is final word of its packet
get  in  1  read strobe
empty  out  1  no committed word available
level  out  ORDER+1  committed words not yet read

Behaviour:
- State: wp (write ptr incl. open packet), head (committed write ptr), rp (read ptr), all ORDER+1 bits, binary, wrap mod 2**(ORDER+1); tail queue of PKTS entries, each holding the ptr of a packet's last word, plus its count (COUNT_ORDER+1 bits).
- Reset (sync, highest priority): wp=head=rp=0, tail queue emptied, out=0, last=0; hence empty=1, full=0, afull=(AF>DEPTH?1:0)=0, level=0, free=DEPTH. All stored and open data discarded, including a packet mid-write.
- Combinational flags: empty = (rp == head); level = head - rp; free = DEPTH - (wp - rp); full = (wp - rp == DEPTH) | (tail count == PKTS); afull = free < AF.
- put accepted iff put & ~full: ram[wp[ORDER-1:0]] <= in, wp++. put while full: ignored, no state change.
- commit: accepted iff the open packet is non-empty (wp_next != head) and the tail queue is not full. Then head <= wp_next, push (wp_next - 1). wp_next includes a put accepted in the same cycle. Empty commit, or commit with the tail queue full: ignored, packet stays open.
- drop: wp <= head. A same-cycle put word is discarded too. drop takes priority over commit when both are asserted.
- get accepted iff get & ~empty. Next cycle: out = ram[rp], last = (rp == tail queue front). rp++; if last, pop the tail queue. Read latency is 1 cycle. get while empty: ignored, out/last hold.
- Same-cycle get of the final committed word and commit of a new packet: pop and push both occur; the count is unchanged.
- Same-cycle put and get with buffer full: get frees a slot only next cycle. full is evaluated from the current state; no bypass.
- Pointer wrap-around: arithmetic is mod 2**(ORDER+1); RAM indexed by low ORDER bits. Full/empty are unambiguous at every wrap.
- No read-during-write hazard: the reader addresses only committed slots; the writer addresses only uncommitted slots.

Test Plan:
- Reset, then put 3 words 0x11,0x22,0x33, commit; 3 gets -> out 0x11,0x22,0x33 one cycle after each get, last=1 only with 0x33; level 3->0; empty=1 after the third get.
- Put 0xA0,0xA1, drop, put 0xB0, commit, get -> out=0xB0, last=1; free back to 16 after the get.
- ORDER=4: put 16 words without commit -> full=1, free=0, afull from free=1; 17th put ignored; commit, 16 gets -> data in order, single last on word 16.
- COUNT_ORDER=2: commit 4 one-word packets -> full=1 with free=12; 5th put ignored; one get -> full=0.
- Put+commit same cycle on a 1-word open packet -> packet holds 2 words. Commit+drop same cycle -> packet discarded, level unchanged.
- Wrap: 40 one-word put/commit/get cycles -> data intact across pointer wrap. Reset mid-packet with 5 words open -> next cycle empty=1, free=16, out=0, last=0.

Source files
------------

// File: rtl/sync_pfifo_if.sv
// Handshake bundle for the single-clock packet FIFO.
// The master is the producer/consumer side; the slave is the FIFO itself.
interface sync_pfifo_if #(
  parameter int W     = 8,
  parameter int ORDER = 4
);
  logic [W-1:0]   in;
  logic           put;
  logic           commit;
  logic           drop;
  logic           full;
  logic           afull;
  logic [ORDER:0] free;
  logic [W-1:0]   out;
  logic           last;
  logic           get;
  logic           empty;
  logic [ORDER:0] level;

  modport master (
    output in, put, commit, drop, get,
    input  full, afull, free, out, last, empty, level
  );

  modport slave (
    input  in, put, commit, drop, get,
    output full, afull, free, out, last, empty, level
  );
endinterface

// File: rtl/sync_pfifo.sv
// Single-clock packet FIFO. Words are written speculatively into an open
// packet that is either committed (made visible to the reader) or dropped.
// A small queue of last-word pointers marks packet ends for the reader.
module sync_pfifo #(
  parameter int W           = 8,
  parameter int ORDER       = 4,
  parameter int COUNT_ORDER = 2,
  parameter int AF          = 2
) (
  input  logic       clock,
  input  logic       reset,
  sync_pfifo_if.slave bus
);
  localparam int DEPTH = 1 << ORDER;
  localparam int PKTS  = 1 << COUNT_ORDER;
  localparam int PW    = ORDER + 1;
  localparam int CW    = COUNT_ORDER + 1;

  logic [W-1:0]           ram [DEPTH];
  logic [PW-1:0]          tail_q [PKTS];

  logic [PW-1:0]          wp, head, rp;
  logic [PW-1:0]          used, free_w, wp_next;
  logic [COUNT_ORDER-1:0] tq_wr, tq_rd;
  logic [CW-1:0]          tq_cnt;
  logic                   tq_full, full_w, empty_w;
  logic                   put_ok, commit_ok, get_ok, is_last, pop;
  logic [W-1:0]           out_q;
  logic                   last_q;

  // wp - rp counts open and committed words; both pointers carry an extra
  // wrap bit so full (difference == DEPTH) and empty (== 0) never alias.
  assign used    = wp - rp;
  assign free_w  = PW'(DEPTH) - used;
  assign tq_full = (tq_cnt == CW'(PKTS));
  assign full_w  = (used == PW'(DEPTH)) | tq_full;
  assign empty_w = (rp == head);

  assign put_ok    = bus.put & ~full_w;
  assign wp_next   = wp + PW'(put_ok);
  assign commit_ok = bus.commit & ~bus.drop & (wp_next != head) & ~tq_full;
  assign get_ok    = bus.get & ~empty_w;
  // The tail queue is never empty while a committed word is unread.
  assign is_last   = (rp == tail_q[tq_rd]);
  assign pop       = get_ok & is_last;

  assign bus.full  = full_w;
  assign bus.afull = free_w < PW'(AF);
  assign bus.free  = free_w;
  assign bus.empty = empty_w;
  assign bus.level = head - rp;
  assign bus.out   = out_q;
  assign bus.last  = last_q;

  // Data store: writer only touches uncommitted slots, so no reset needed.
  always_ff @(posedge clock) begin
    if (put_ok) ram[wp[ORDER-1:0]] <= bus.in;
  end

  // Packet-end pointer store; contents are only meaningful below tq_cnt.
  always_ff @(posedge clock) begin
    if (!reset && commit_ok) tail_q[tq_wr] <= wp_next - PW'(1);
  end

  // Pointers, tail-queue bookkeeping and the registered read port.
  always_ff @(posedge clock) begin
    if (reset) begin
      wp     <= '0;
      head   <= '0;
      rp     <= '0;
      tq_wr  <= '0;
      tq_rd  <= '0;
      tq_cnt <= '0;
      out_q  <= '0;
      last_q <= 1'b0;
    end else begin
      // drop rewinds to the committed pointer, discarding a same-cycle put too
      if (bus.drop) wp <= head;
      else          wp <= wp_next;

      if (commit_ok) begin
        head  <= wp_next;
        tq_wr <= tq_wr + 1'b1;
      end

      if (get_ok) begin
        out_q  <= ram[rp[ORDER-1:0]];
        last_q <= is_last;
        rp     <= rp + PW'(1);
      end

      if (pop) tq_rd <= tq_rd + 1'b1;

      tq_cnt <= tq_cnt + CW'(commit_ok) - CW'(pop);
    end
  end
endmodule
